// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer for the single-cycle core.
// Chooses the next PC from start address, held PC, branch target or PC+1,
// runs the start/run/done handshake, flags taken branches through index 0,
// and counts RUN cycles with saturation.
module pc_fetch_ctrl #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          halt,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_cond,
  input  logic [4:0]    branch_idx,
  input  logic [D-1:0]  target,
  output logic [4:0]    lut_addr,
  output logic [D-1:0]  pc,
  output logic          fetch_valid,
  output logic          done,
  output logic          bad_target,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic          bad_q, bad_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          done_q, done_d;
  logic          take_s;

  // The lookup index is a straight wire so the target returns in the same cycle.
  assign lut_addr = branch_idx;
  assign take_s   = branch_en & branch_cond;

  // Next-state, next-PC, counter and sticky-flag selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Starting from either resting state is identical: fresh program.
        if (start) begin
          state_d = ST_RUN;
          pc_d    = start_addr;
          cnt_d   = {CW{1'b0}};
          bad_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // Every RUN cycle counts, including stall and halt cycles.
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // Priority: halt > stall > taken branch > increment.
        if (halt) begin
          state_d = ST_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (take_s) begin
          if (branch_idx != 5'd0) begin
            pc_d = target;
          end else begin
            // Index 0 is "no entry": fall through and remember the error.
            pc_d  = pc_q + PC_ONE;
            bad_d = 1'b1;
          end
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they leave a flop glitch-free.
  always_comb begin
    fetch_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_d)
      ST_RUN:  fetch_valid_d = 1'b1;
      ST_DONE: done_d        = 1'b1;
      default: begin
        fetch_valid_d = 1'b0;
        done_d        = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= {D{1'b0}};
      bad_q         <= 1'b0;
      cnt_q         <= {CW{1'b0}};
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      bad_q         <= bad_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;
  assign bad_target  = bad_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic against a behavioural model; a second small instance covers PC
// wrap and counter saturation.
module tb_pc_fetch_ctrl;
  localparam int D  = 12;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start, halt, stall, branch_en, branch_cond;
  logic [D-1:0]  start_addr, target;
  logic [4:0]    branch_idx, lut_addr;
  logic [D-1:0]  pc;
  logic          fetch_valid, done, bad_target;
  logic [CW-1:0] cycle_count;

  logic [D-1:0]  lut [32];
  assign target = lut[lut_addr];

  pc_fetch_ctrl #(.D(D), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .halt(halt), .stall(stall), .branch_en(branch_en), .branch_cond(branch_cond),
    .branch_idx(branch_idx), .target(target), .lut_addr(lut_addr), .pc(pc),
    .fetch_valid(fetch_valid), .done(done), .bad_target(bad_target),
    .cycle_count(cycle_count)
  );

  // Small instance: D=4, CW=3.
  logic       s_start;
  logic [3:0] s_addr, s_pc;
  logic [4:0] s_lut;
  logic       s_fv, s_done, s_bad;
  logic [2:0] s_cnt;

  pc_fetch_ctrl #(.D(4), .CW(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .start_addr(s_addr),
    .halt(1'b0), .stall(1'b0), .branch_en(1'b0), .branch_cond(1'b0),
    .branch_idx(5'd0), .target(4'd0), .lut_addr(s_lut), .pc(s_pc),
    .fetch_valid(s_fv), .done(s_done), .bad_target(s_bad), .cycle_count(s_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: running/finished flags and plain integer arithmetic.
  int m_pc, m_cnt;
  bit m_run, m_fin, m_bad;

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_run = 0; m_fin = 0; m_bad = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_run) begin
      m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      if (halt) begin
        m_run = 0; m_fin = 1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (branch_en && branch_cond && branch_idx != 0) begin
        m_pc = int'(lut[branch_idx]);
      end else begin
        if (branch_en && branch_cond) m_bad = 1;
        m_pc = (m_pc + 1) % (1 << D);
      end
    end else if (start) begin
      m_pc = int'(start_addr); m_cnt = 0; m_bad = 0; m_run = 1; m_fin = 0;
    end
  endtask

  task automatic compare_all();
    check_val("pc", 32'(pc), 32'(m_pc));
    check_val("fetch_valid", 32'(fetch_valid), 32'(m_run));
    check_val("done", 32'(done), 32'(m_fin));
    check_val("bad_target", 32'(bad_target), 32'(m_bad));
    check_val("cycle_count", 32'(cycle_count), 32'(m_cnt));
    check_val("lut_addr", 32'(lut_addr), 32'(branch_idx));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; branch_cond = 1'b0; branch_idx = 5'd0;
  endtask

  // Bring the block to RUN at addr from any state.
  task automatic restart(input logic [D-1:0] addr);
    idle_inputs(); halt = 1'b1;
    step();
    idle_inputs(); start = 1'b1; start_addr = addr;
    step();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = D'($urandom_range(0, (1 << D) - 1));
    lut[3] = 12'd48;
    lut[2] = 12'd15;
    reset_n = 1'b0;
    idle_inputs();
    start_addr = '0;
    s_start = 1'b0; s_addr = 4'd0;
    model_reset();

    // Reset held for two cycles.
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    reset_n = 1'b1;

    // Small instance: wrap 14,15,0 and saturation after 9 RUN cycles.
    s_start = 1'b1; s_addr = 4'd14;
    step();
    check_val("small_pc_start", 32'(s_pc), 32'd14);
    check_val("small_fv", 32'(s_fv), 32'd1);
    s_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_val("small_pc", 32'(s_pc), 32'((14 + k) % 16));
      check_val("small_cnt", 32'(s_cnt), 32'((k > 7) ? 7 : k));
    end

    // Start at 0 and step 0,1,2,3.
    start = 1'b1; start_addr = '0;
    step();
    check_val("start_pc", 32'(pc), 32'd0);
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      step();
      check_val("seq_pc", 32'(pc), 32'(k));
    end

    // Taken branch at 5 -> 48; not-taken branch at 5 -> 6.
    restart(12'd5);
    branch_en = 1'b1; branch_cond = 1'b1; branch_idx = 5'd3;
    step();
    check_val("branch_taken", 32'(pc), 32'd48);
    restart(12'd5);
    branch_en = 1'b1; branch_cond = 1'b0; branch_idx = 5'd3;
    step();
    check_val("branch_not_taken", 32'(pc), 32'd6);

    // Stall beats branch, then branch taken.
    restart(12'd20);
    stall = 1'b1; branch_en = 1'b1; branch_cond = 1'b1; branch_idx = 5'd2;
    step();
    check_val("stall_over_branch", 32'(pc), 32'd20);
    stall = 1'b0;
    step();
    check_val("branch_after_stall", 32'(pc), 32'd15);

    // Halt beats branch.
    restart(12'd30);
    halt = 1'b1; branch_en = 1'b1; branch_cond = 1'b1; branch_idx = 5'd3;
    step();
    check_val("halt_pc", 32'(pc), 32'd30);
    check_val("halt_done", 32'(done), 32'd1);

    // Index 0 sets sticky flag; restart clears it.
    restart(12'd10);
    branch_en = 1'b1; branch_cond = 1'b1; branch_idx = 5'd0;
    step();
    check_val("bad_pc", 32'(pc), 32'd11);
    check_val("bad_flag", 32'(bad_target), 32'd1);
    idle_inputs(); halt = 1'b1;
    step();
    check_val("bad_through_halt", 32'(bad_target), 32'd1);
    idle_inputs(); start = 1'b1; start_addr = 12'd17;
    step();
    check_val("bad_cleared", 32'(bad_target), 32'd0);
    check_val("restart_pc", 32'(pc), 32'd17);
    idle_inputs();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      start       = ($urandom_range(0, 3) == 0);
      start_addr  = D'($urandom_range(0, (1 << D) - 1));
      halt        = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      branch_en   = ($urandom_range(0, 1) == 1);
      branch_cond = ($urandom_range(0, 1) == 1);
      branch_idx  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step();
    end

    // Asynchronous reset mid-RUN at pc=40.
    restart(12'd38);
    step();
    step();
    check_val("pre_reset_pc", 32'(pc), 32'd40);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("wait_for_start", 32'(pc), 32'd0);
    end
    start = 1'b1; start_addr = 12'd7;
    step();
    check_val("post_reset_start", 32'(pc), 32'd7);
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
